// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch and data requester handshakes plus the shared memory port.
// The master modport is the arbiter's view; the slave modport is the requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              addr_sel;
    logic              mem_valid;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_err;

    modport master (
        input  if_req, d_req, d_we, d_wdata, mem_ready, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
        output addr_sel, mem_valid, mem_we, mem_wdata, bus_err
    );

    modport slave (
        output if_req, d_req, d_we, d_wdata, mem_ready, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
        input  addr_sel, mem_valid, mem_we, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with a watchdog abort.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);
    localparam logic [7:0]        LIMIT_M1   = 8'(TIMEOUT - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        wait_cnt_reg;
    logic              addr_sel_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              if_done_reg;
    logic              d_done_reg;
    logic              bus_err_reg;

    logic              elig_i;
    logic              elig_d;
    logic              pick_d;
    logic              granted;
    logic              timeout_hit;
    logic              txn_end;

    logic              mem_valid;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // A requester whose done pulse is visible this cycle still holds req high; mask it.
    assign elig_i = bus.if_req & ~if_done_reg;
    assign elig_d = bus.d_req  & ~d_done_reg;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_reg;

    // last_d_reg = 1 means data was served last, so fetch is preferred (reset state).
    assign pick_d = elig_d & (~elig_i | ~last_d_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_reg <= 1'b1;
        end else if (txn_end) begin
            last_d_reg <= (state_reg == GRANT_D);
        end
    end
`else
    assign pick_d = elig_d;
`endif

    assign granted     = (state_reg == GRANT_I) || (state_reg == GRANT_D);
    // Ready on the limit cycle wins over the abort.
    assign timeout_hit = granted & ~bus.mem_ready & (wait_cnt_reg == LIMIT_M1);
    assign txn_end     = granted & (bus.mem_ready | timeout_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_d) begin
                    state_next = GRANT_D;
                end else if (elig_i) begin
                    state_next = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (txn_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_reg)
            GRANT_I: begin
                mem_valid = 1'b1;
                mem_wdata = bus.d_wdata;
            end
            GRANT_D: begin
                mem_valid = 1'b1;
                mem_we    = bus.d_we;
                mem_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            addr_sel_reg <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            if_done_reg  <= 1'b0;
            d_done_reg   <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            if_done_reg <= 1'b0;
            d_done_reg  <= 1'b0;
            bus_err_reg <= 1'b0;
            if (state_reg == IDLE) begin
                wait_cnt_reg <= '0;
                if (state_next == GRANT_D) begin
                    addr_sel_reg <= 1'b1;
                end else if (state_next == GRANT_I) begin
                    addr_sel_reg <= 1'b0;
                end
            end else if (txn_end) begin
                bus_err_reg <= timeout_hit;
                if (state_reg == GRANT_D) begin
                    d_done_reg  <= 1'b1;
                    d_rdata_reg <= timeout_hit ? ABORT_DATA : bus.mem_rdata;
                end else begin
                    if_done_reg  <= 1'b1;
                    if_rdata_reg <= timeout_hit ? ABORT_DATA : bus.mem_rdata;
                end
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.addr_sel  = addr_sel_reg;
    assign bus.mem_valid = mem_valid;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.if_done   = if_done_reg;
    assign bus.d_done    = d_done_reg;
    assign bus.bus_err   = bus_err_reg;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port memory arbiter for the 32-bit MIPS core; shares one memory port between instruction fetch (IF) and data load/store (D).
- Drives the select of the existing 32-bit 2:1 address mux: inp0 = IF address, inp1 = D address.
- Sequences each memory transaction through a valid/ready handshake and returns read data and a done pulse to the winning requester.
- Watchdog aborts hung transactions.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT, 15, maximum wait cycles for mem_ready before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_done
- if_rdata  out  DATA_W  fetched instruction, registered
- if_done  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1 = store, 0 = load; stable while d_req high
- d_wdata  in  DATA_W  store data; stable while d_req high
- d_rdata  out  DATA_W  load data, registered
- d_done  out  1  one-cycle completion pulse to data
- addr_sel  out  1  address mux select; 0 = IF, 1 = D
- mem_valid  out  1  transaction request to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  write data to memory
- mem_ready  in  1  memory accepts/completes in this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- bus_err  out  1  one-cycle pulse with done on timeout abort

Behaviour:
- Reset (async, active-high, any cycle including mid-transaction): state IDLE, all outputs 0, wait counter 0, RR pointer prefers IF. Any in-flight transaction is abandoned with no done pulse.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: eligible requests are if_req & ~if_done and d_req & ~d_done. A requester whose done is high this cycle is masked, so its still-high req is never served twice.
  - Only one eligible: grant it.
  - Both eligible: D wins (fixed priority; see optional feature).
  - None eligible: stay in IDLE.
- Grant transitions: IDLE→GRANT_I sets addr_sel=0. IDLE→GRANT_D sets addr_sel=1. addr_sel is registered and holds its value through IDLE until the next grant.
- In GRANT_x: mem_valid=1 (combinational from state); mem_we = d_we in GRANT_D, else 0; mem_wdata = d_wdata.
- Completion: on the edge where mem_valid & mem_ready, capture mem_rdata into if_rdata or d_rdata (stores capture too, value don't-care). Pulse the matching done for exactly one cycle. Return to IDLE.
- Minimum latency: req seen in IDLE at edge N, mem_valid high in cycle N+1. If mem_ready is high in N+1, done is high in cycle N+2. Back-to-back grants are separated by one IDLE cycle.
- Watchdog: 8-bit counter cleared on entering GRANT_x, incremented each GRANT cycle without mem_ready. When the counter equals TIMEOUT without mem_ready: abort, pulse done and bus_err together, load rdata with 32'hDEADBEEF, return to IDLE. mem_ready arriving in the same cycle as the limit counts as completion, not abort.
- A requester dropping req mid-transaction has no effect; the transaction completes normally.
- if_rdata and d_rdata hold their last value between transactions.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-served pointer updates on each completion or abort. On simultaneous eligible requests, the requester not served last wins. Reset state prefers IF.
- Undefined: fixed D-over-IF priority; no pointer register.

Test Plan:
- Reset mid-GRANT_D with mem_valid=1 → next cycle mem_valid=0, addr_sel=0, d_done never pulses.
- if_req only, mem_ready=1 in the first valid cycle, mem_rdata=32'h8C220004 → addr_sel=0, mem_valid for 1 cycle, if_done pulses 2 cycles after request, if_rdata=32'h8C220004.
- d_req store, d_we=1, d_wdata=32'h12345678, mem_ready delayed 3 cycles → mem_we=1 and mem_valid for 4 cycles, addr_sel=1, single d_done pulse.
- if_req and d_req high together, both held; mem_ready always 1 → without macro: D then IF. With ARB_ROUND_ROBIN_EN from reset: IF then D. One IDLE cycle between grants; no duplicate service.
- mem_ready stuck 0, TIMEOUT=15, if_req → mem_valid for 15 cycles, then if_done and bus_err pulse together, if_rdata=32'hDEADBEEF, state IDLE.
- mem_ready rises on the 15th wait cycle → normal completion, bus_err=0, rdata equals mem_rdata.
